// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem request/grant/response
// handshake, holds each fetched word for the core and flags timeout/misaligned faults.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0100,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fault,
    output logic [31:0] instret
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        VALID = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t          state_reg, state_next;
    logic [31:0]     pc_reg, pc_next;
    logic [31:0]     inst_reg, inst_next;
    logic [31:0]     instret_reg, instret_next;
    logic [CW-1:0]   wait_cnt_reg, wait_cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg       <= RESET_PC;
            inst_reg     <= '0;
            instret_reg  <= '0;
            wait_cnt_reg <= '0;
        end else begin
            pc_reg       <= pc_next;
            inst_reg     <= inst_next;
            instret_reg  <= instret_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        inst_next     = inst_reg;
        instret_next  = instret_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            IDLE: state_next = REQ;
            REQ: begin
                if (imem_gnt) begin
                    state_next    = WAIT;
                    wait_cnt_next = '0;
                end
            end
            WAIT: begin
                // A response on the last allowed cycle still wins over the timeout.
                if (imem_rvalid) begin
                    inst_next  = imem_rdata;
                    state_next = VALID;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                    if (wait_cnt_reg == WAIT_LAST) begin
                        state_next = FAULT;
                    end
                end
            end
            VALID: begin
                if (inst_ready) begin
                    if (!redirect_valid) begin
                        pc_next      = pc_reg + 32'd4;
                        instret_next = instret_reg + 32'd1;
                        state_next   = REQ;
                    end else if (redirect_target[1:0] == 2'b00) begin
                        pc_next      = redirect_target;
                        instret_next = instret_reg + 32'd1;
                        state_next   = REQ;
                    end else begin
                        state_next = FAULT;
                    end
                end
            end
            FAULT:   state_next = FAULT;
            default: state_next = IDLE;
        endcase
    end

    assign imem_req   = (state_reg == REQ);
    assign inst_valid = (state_reg == VALID);
    assign fault      = (state_reg == FAULT);
    assign imem_addr  = pc_reg;
    assign inst_pc    = pc_reg;
    assign inst       = inst_reg;
    assign instret    = instret_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: randomized memory/core timing against a
// transaction-level PC/instret model.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          TIMEOUT  = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        fault;
    logic [31:0] instret;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_pc;
    logic [31:0] exp_ret;
    bit          exp_fault;

    fetch_ctrl #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .fault(fault), .instret(instret)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in REQ (one cycle of IDLE after release).
    task automatic apply_reset();
        rst = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_target = '0; imem_rdata = $urandom;
        step(); step();
        rst = 1'b0;
        exp_pc = RESET_PC; exp_ret = '0; exp_fault = 1'b0;
        step();
    endtask

    // One full fetch transaction starting in REQ; expected values from the model.
    task automatic fetch_one(input int gd, input int rd, input int qd,
                             input bit redir, input logic [31:0] tgt);
        logic [31:0] word;
        logic [31:0] old_pc;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
            bad++;
            $display("FAIL req_start: req=%0b addr=%h want req=1 addr=%h", imem_req, imem_addr, exp_pc);
        end
        for (int i = 0; i < gd; i++) begin
            imem_gnt = 1'b0; imem_rvalid = 1'($urandom_range(0, 1));
            inst_ready = 1'($urandom_range(0, 1));
            redirect_valid = 1'($urandom_range(0, 1)); redirect_target = $urandom;
            step();
            total++;
            if (imem_req !== 1'b1 || imem_addr !== exp_pc || inst_valid !== 1'b0) begin
                bad++;
                $display("FAIL req_hold: req=%0b addr=%h iv=%0b want 1 %h 0", imem_req, imem_addr, inst_valid, exp_pc);
            end
        end
        imem_gnt = 1'b1; imem_rvalid = 1'($urandom_range(0, 1));
        step();
        imem_gnt = 1'b0;
        for (int i = 0; i < rd; i++) begin
            imem_rvalid = 1'b0;
            inst_ready = 1'($urandom_range(0, 1));
            redirect_valid = 1'($urandom_range(0, 1)); redirect_target = $urandom;
            step();
            total++;
            if (imem_req !== 1'b0 || inst_valid !== 1'b0 || fault !== 1'b0) begin
                bad++;
                $display("FAIL wait: req=%0b iv=%0b fault=%0b want 0 0 0", imem_req, inst_valid, fault);
            end
        end
        word = mem_word(exp_pc);
        imem_rvalid = 1'b1; imem_rdata = word; inst_ready = 1'b0; redirect_valid = 1'b0;
        step();
        imem_rvalid = 1'b0; imem_rdata = $urandom;
        total++;
        if (inst_valid !== 1'b1 || inst !== word || inst_pc !== exp_pc || instret !== exp_ret) begin
            bad++;
            $display("FAIL valid: iv=%0b inst=%h pc=%h ret=%0d want 1 %h %h %0d",
                     inst_valid, inst, inst_pc, instret, word, exp_pc, exp_ret);
        end
        for (int i = 0; i < qd; i++) begin
            inst_ready = 1'b0; imem_rvalid = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
            redirect_valid = 1'($urandom_range(0, 1)); redirect_target = $urandom;
            step();
            total++;
            if (inst_valid !== 1'b1 || inst !== word || inst_pc !== exp_pc || imem_req !== 1'b0) begin
                bad++;
                $display("FAIL valid_hold: iv=%0b inst=%h pc=%h want 1 %h %h", inst_valid, inst, inst_pc, word, exp_pc);
            end
        end
        inst_ready = 1'b1; imem_rvalid = 1'b0;
        redirect_valid = redir; redirect_target = tgt;
        step();
        inst_ready = 1'b0; redirect_valid = 1'b0;
        old_pc = exp_pc;
        if (redir && tgt[1:0] != 2'b00) begin
            exp_fault = 1'b1;
        end else begin
            exp_pc  = redir ? tgt : exp_pc + 32'd4;
            exp_ret = exp_ret + 32'd1;
        end
        total++;
        if (exp_fault) begin
            if (fault !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 ||
                imem_addr !== exp_pc || instret !== exp_ret) begin
                bad++;
                $display("FAIL accept_fault: fault=%0b req=%0b iv=%0b addr=%h ret=%0d want 1 0 0 %h %0d",
                         fault, imem_req, inst_valid, imem_addr, instret, exp_pc, exp_ret);
            end
        end else begin
            if (fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp_pc || instret !== exp_ret) begin
                bad++;
                $display("FAIL accept: fault=%0b req=%0b addr=%h ret=%0d want 0 1 %h %0d",
                         fault, imem_req, imem_addr, instret, exp_pc, exp_ret);
            end
        end
        $display("fetch pc=%h inst=%h redir=%0b tgt=%h -> next=%h instret=%0d fault=%0b",
                 old_pc, word, redir, tgt, exp_pc, exp_ret, exp_fault);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        total++;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC || inst !== 32'd0 || inst_pc !== RESET_PC ||
            inst_valid !== 1'b0 || fault !== 1'b0 || instret !== 32'd0) begin
            bad++;
            $display("FAIL reset_values: req=%0b addr=%h inst=%h pc=%h iv=%0b fault=%0b ret=%0d",
                     imem_req, imem_addr, inst, inst_pc, inst_valid, fault, instret);
        end
        rst = 1'b0;
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("FAIL boot_idle: req=%0b want 0", imem_req);
        end
        step();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            bad++;
            $display("FAIL boot_req: req=%0b addr=%h want 1 %h", imem_req, imem_addr, RESET_PC);
        end
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
        total++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL boot_wait: iv=%0b req=%0b want 0 0", inst_valid, imem_req);
        end
        step();
        imem_rvalid = 1'b0;
        total++;
        if (inst_valid !== 1'b1 || inst !== 32'h0000_0013 || inst_pc !== RESET_PC || instret !== 32'd0) begin
            bad++;
            $display("FAIL boot_valid: iv=%0b inst=%h pc=%h ret=%0d want 1 00000013 %h 0",
                     inst_valid, inst, inst_pc, instret, RESET_PC);
        end
        $display("boot inst=%h pc=%h", inst, inst_pc);
    endtask

    task automatic test_sequential();
        apply_reset();
        for (int i = 0; i < 3; i++) fetch_one(2, 0, 4, 1'b0, 32'd0);
        total++;
        if (instret !== 32'd3 || imem_addr !== 32'h0000_010C) begin
            bad++;
            $display("FAIL seq_count: ret=%0d addr=%h want 3 0000010c", instret, imem_addr);
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        fetch_one(0, 0, 0, 1'b0, 32'd0);
        fetch_one(1, 1, 1, 1'b1, 32'h0000_0200);
        fetch_one(0, 0, 0, 1'b1, 32'hFFFF_FFFC);
        fetch_one(0, 0, 0, 1'b0, 32'd0);
    endtask

    task automatic test_misaligned();
        apply_reset();
        fetch_one(0, 0, 0, 1'b0, 32'd0);
        fetch_one(0, 1, 2, 1'b1, 32'h0000_0202);
        for (int i = 0; i < 4; i++) begin
            imem_gnt = 1'($urandom_range(0, 1)); imem_rvalid = 1'($urandom_range(0, 1));
            inst_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_0300;
            step();
            total++;
            if (fault !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h0000_0104 || instret !== 32'd1) begin
                bad++;
                $display("FAIL fault_sticky: fault=%0b req=%0b addr=%h ret=%0d want 1 0 00000104 1",
                         fault, imem_req, imem_addr, instret);
            end
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            imem_rvalid = 1'b0;
            step();
            total++;
            if (fault !== (i == TIMEOUT) || inst_valid !== 1'b0 || imem_req !== 1'b0) begin
                bad++;
                $display("FAIL timeout_cycle%0d: fault=%0b iv=%0b req=%0b want fault=%0b",
                         i, fault, inst_valid, imem_req, (i == TIMEOUT));
            end
        end
        imem_rvalid = 1'b1;
        step(); step();
        imem_rvalid = 1'b0;
        total++;
        if (fault !== 1'b1 || inst_valid !== 1'b0 || imem_req !== 1'b0 || instret !== 32'd0) begin
            bad++;
            $display("FAIL timeout_sticky: fault=%0b iv=%0b req=%0b ret=%0d", fault, inst_valid, imem_req, instret);
        end
        apply_reset();
        fetch_one(0, TIMEOUT - 1, 0, 1'b0, 32'd0);
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        fetch_one(0, 0, 0, 1'b0, 32'd0);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (imem_addr !== RESET_PC || inst !== 32'd0 || instret !== 32'd0 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: addr=%h inst=%h ret=%0d req=%0b", imem_addr, inst, instret, imem_req);
        end
        step();
        rst = 1'b0;
        exp_pc = RESET_PC; exp_ret = '0; exp_fault = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC || inst_valid !== 1'b0 || inst !== 32'd0) begin
            bad++;
            $display("FAIL stale_rvalid: req=%0b addr=%h iv=%0b inst=%h", imem_req, imem_addr, inst_valid, inst);
        end
        fetch_one(0, 0, 0, 1'b0, 32'd0);
    endtask

    task automatic test_random();
        logic [31:0] t;
        apply_reset();
        for (int n = 0; n < 60; n++) begin
            t = $urandom;
            t[1:0] = 2'b00;
            if ($urandom_range(0, 9) == 0) t[1:0] = 2'($urandom_range(1, 3));
            fetch_one($urandom_range(0, 3), $urandom_range(0, TIMEOUT - 1), $urandom_range(0, 3),
                      ($urandom_range(0, 2) == 0), t);
            if (exp_fault) apply_reset();
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect();
        test_misaligned();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer that owns the architectural program counter and drives it through a request/grant/response handshake to instruction memory. Each fetched word is held for the core with its PC until the core accepts it. On acceptance it advances to PC+4 or to a branch/jump target supplied by the core. It sits between the PC datapath (PC register, +4 adder, target adder, next-PC mux) and the instruction memory port, and adds response-timeout and misaligned-target fault detection.

## Interface
- RESET_PC, 32'h0000_0100: PC value loaded on reset.
- TIMEOUT, 15: maximum WAIT cycles without imem_rvalid before fault (≥1).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, equal to the current PC.
- imem_gnt  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  read data.
- inst_valid  out  1  instruction held for core.
- inst  out  32  held instruction word.
- inst_pc  out  32  PC of held instruction.
- inst_ready  in  1  core consumes instruction this cycle.
- redirect_valid  in  1  take redirect_target instead of PC+4; qualified by inst_valid&&inst_ready.
- redirect_target  in  32  next PC for taken branch/jump (PC+imm computed by core).
- fault  out  1  sticky fault flag.
- instret  out  32  count of accepted instructions.

## Operation
- States: IDLE, REQ, WAIT, VALID, FAULT. Reset state is IDLE.
- IDLE: all handshake outputs low. Unconditionally goes to REQ on the next edge.
- REQ: imem_req=1 and imem_addr=pc. If imem_gnt=1, go to WAIT and clear the wait counter. Otherwise stay in REQ with imem_addr stable. imem_rvalid is ignored in REQ.
- WAIT: imem_req=0.
  - imem_rvalid=1: capture imem_rdata into inst, go to VALID.
  - Else: increment the wait counter. When the counter reaches TIMEOUT (TIMEOUT cycles without rvalid), go to FAULT.
  - rvalid in the same cycle the limit is reached: rvalid wins.
- VALID: inst_valid=1; inst and inst_pc are stable. imem_rvalid is ignored. On inst_ready:
  - redirect_valid=0: pc <= pc+4 (mod 2^32; wraps at 32'hFFFF_FFFC to 0). instret increments. Go to REQ.
  - redirect_valid=1 and redirect_target[1:0]==0: pc <= redirect_target. instret increments. Go to REQ.
  - redirect_valid=1 and redirect_target[1:0]!=0: pc unchanged, instret unchanged, go to FAULT.
  - Without inst_ready, hold indefinitely.
- redirect_valid/redirect_target are ignored unless inst_valid&&inst_ready.
- FAULT: fault=1, imem_req=0, inst_valid=0. Sticky until rst.
- instret is a 32-bit counter and wraps to 0 after 32'hFFFF_FFFF.
- inst_pc always equals pc; the PC only changes on acceptance.

## Timing
- Reset values (asynchronous): pc=RESET_PC, imem_addr=RESET_PC, inst=0, inst_pc=RESET_PC, imem_req=0, inst_valid=0, fault=0, instret=0, wait counter=0.
- First imem_req is on the first cycle after the first clk edge following rst deassertion.
- Minimum latency, with gnt in the REQ cycle and rvalid in the first WAIT cycle: REQ cycle N, WAIT N+1, inst_valid at N+2.
- Throughput ceiling is 1 instruction per 3 cycles (REQ, WAIT, VALID).
- Memory contract: rvalid comes at least one cycle after gnt, with exactly one response per grant.
- rst mid-operation: immediate return to reset values. A late rvalid arriving after reset lands in IDLE/REQ and is ignored.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.

## Test plan
- Reset/boot: assert rst, release. Memory grants immediately, responds 1 cycle later with 32'h0000_0013 → imem_addr=0x100, inst_valid at cycle 3 with inst=0x00000013, inst_pc=0x100, instret=0.
- Sequential fetch with backpressure: gnt delayed 2 cycles, inst_ready held low 4 cycles, then accept 3 instructions → addresses 0x100, 0x104, 0x108. imem_addr stable while waiting for gnt. instret=3.
- Redirect: accept at PC 0x104 with redirect_valid=1, target 0x200 → next imem_addr=0x200, instret increments. Redirect asserted while inst_valid=0 has no effect.
- Misaligned redirect: target 0x202 on accept → fault=1 next cycle, pc remains 0x104, instret unchanged, no further imem_req until rst.
- Timeout: gnt then no rvalid for 15 WAIT cycles → fault=1. Repeat with rvalid on the 15th WAIT cycle → inst_valid, no fault.
- Reset mid-WAIT: assert rst after gnt, release, then drive stale rvalid in IDLE → ignored. Fresh fetch from 0x100 completes normally.
